// File: rtl/mac_vec_driver_if.sv
// mac_vec_driver_if: table-load port, run control, MAC-facing signals and run status of mac_vec_driver.
interface mac_vec_driver_if #(parameter int W = 10, parameter int AW = 10);
  logic st_we, st_valid, st_clr, ex_we, ex_valid, start;
  logic [AW-1:0] st_addr, ex_addr, first_err;
  logic [W-1:0] st_a, st_b, mac_a, mac_b;
  logic [2*W-1:0] ex_f, mac_f;
  logic [AW:0] num_vec;
  logic mac_valid_in, mac_clr, mac_valid_out, busy, done, pass;
  logic [15:0] err_count;
  modport slave (
    input st_we, st_addr, st_a, st_b, st_valid, st_clr, ex_we, ex_addr, ex_valid, ex_f, num_vec, start,
    input mac_f, mac_valid_out,
    output mac_a, mac_b, mac_valid_in, mac_clr, busy, done, err_count, first_err, pass
  );
  modport master (
    output st_we, st_addr, st_a, st_b, st_valid, st_clr, ex_we, ex_addr, ex_valid, ex_f, num_vec, start,
    output mac_f, mac_valid_out,
    input mac_a, mac_b, mac_valid_in, mac_clr, busy, done, err_count, first_err, pass
  );
endinterface

// File: rtl/mac_vec_driver.sv
// mac_vec_driver: plays a RAM-held stimulus table into part3_mac and checks its outputs against an expected table.
module mac_vec_driver #(
  parameter int W = 10,
  parameter int DEPTH = 1024,
  parameter bit CHECK_VALID = 1'b1
) (
  input logic clk,
  input logic reset,
  mac_vec_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = 2*W + 2;
  localparam int EW = 2*W + 1;
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [SW-1:0] st_mem [DEPTH];
  logic [EW-1:0] ex_mem [DEPTH];
  logic [SW-1:0] st_rd_q;
  logic [EW-1:0] ex_rd_q, ex_cur_q, ex_cur_d;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, rd_addr, first_err_q, first_err_d;
  logic [AW:0] n_q, n_d;
  logic [W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic mac_valid_in_q, mac_valid_in_d, mac_clr_q, mac_clr_d, pass_q, pass_d;
  logic [15:0] err_count_q, err_count_d;
  logic [2*W-1:0] ex_f;
  logic ex_v, go, last, mism, hit;
  assign {ex_v, ex_f} = ex_cur_q;
  always_ff @(posedge clk) begin
    if (bus.st_we) st_mem[bus.st_addr] <= {bus.st_a, bus.st_b, bus.st_valid, bus.st_clr};
    if (bus.ex_we) ex_mem[bus.ex_addr] <= {bus.ex_valid, bus.ex_f};
    st_rd_q <= st_mem[rd_addr];
    ex_rd_q <= ex_mem[rd_addr];
  end
  // The RAM runs one entry ahead of the MAC ports; the expected entry is re-registered to line up with vector i.
  always_comb begin
    go = state_q == IDLE && bus.start;
    last = {1'b0, idx_q} == n_q - 1'b1;
    mism = CHECK_VALID ? (bus.mac_valid_out != ex_v) || (ex_v && bus.mac_f != ex_f)
                       : bus.mac_valid_out && bus.mac_f != ex_f;
    hit = state_q == RUN && mism;
    state_d = go ? ((bus.num_vec == '0) ? DONE : PRIME)
      : (state_q == PRIME) ? RUN
      : (state_q == RUN) ? (last ? DONE : RUN)
      : IDLE;
    n_d = go ? ((bus.num_vec > DEPTH_N) ? DEPTH_N : bus.num_vec) : n_q;
    idx_d = (state_q == RUN) ? idx_q + 1'b1 : '0;
    rd_addr = (state_q == PRIME) ? AW'(1) : (state_q == RUN) ? idx_q + AW'(2) : '0;
    {mac_a_d, mac_b_d, mac_valid_in_d, mac_clr_d} = (state_d == RUN) ? st_rd_q : SW'(1);
    ex_cur_d = (state_d == RUN) ? ex_rd_q : ex_cur_q;
    err_count_d = go ? '0 : (hit && err_count_q != 16'hFFFF) ? err_count_q + 1'b1 : err_count_q;
    first_err_d = go ? '0 : (hit && err_count_q == '0) ? idx_q : first_err_q;
    pass_d = go ? 1'b0 : (state_q == DONE) ? err_count_q == '0 : pass_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q <= '0;
      idx_q <= '0;
      ex_cur_q <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      mac_valid_in_q <= 1'b0;
      mac_clr_q <= 1'b1;
      err_count_q <= '0;
      first_err_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      idx_q <= idx_d;
      ex_cur_q <= ex_cur_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
      mac_valid_in_q <= mac_valid_in_d;
      mac_clr_q <= mac_clr_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q <= pass_d;
    end
  end
  assign bus.mac_a = mac_a_q;
  assign bus.mac_b = mac_b_q;
  assign bus.mac_valid_in = mac_valid_in_q;
  assign bus.mac_clr = mac_clr_q;
  assign bus.busy = state_q == PRIME || state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.err_count = err_count_q;
  assign bus.first_err = first_err_q;
  assign bus.pass = pass_q;
endmodule

// File: tb/tb_mac_vec_driver.sv
// tb_mac_vec_driver: directed vectors against two drivers (CHECK_VALID=1 and 0) sharing a behavioural part3_mac.
module tb_mac_vec_driver;
  localparam int W = 10, DEPTH = 1024, AW = 10;
  logic clk = 0, reset = 0;
  int tests = 0, fails = 0;
  logic st_we = 0, st_valid = 0, st_clr = 0, ex_we = 0, ex_valid = 0, start = 0;
  logic [AW-1:0] st_addr = '0, ex_addr = '0;
  logic [W-1:0] st_a = '0, st_b = '0;
  logic [2*W-1:0] ex_f = '0;
  logic [AW:0] num_vec = '0;
  logic signed [2*W-1:0] ref_f;
  logic ref_v;
  logic [2*W+1:0] got_p, exp_p;
  mac_vec_driver_if #(.W(W), .AW(AW)) b1 ();
  mac_vec_driver_if #(.W(W), .AW(AW)) b0 ();
  assign {b1.st_we, b1.st_addr, b1.st_a, b1.st_b, b1.st_valid, b1.st_clr} = {st_we, st_addr, st_a, st_b, st_valid, st_clr};
  assign {b0.st_we, b0.st_addr, b0.st_a, b0.st_b, b0.st_valid, b0.st_clr} = {st_we, st_addr, st_a, st_b, st_valid, st_clr};
  assign {b1.ex_we, b1.ex_addr, b1.ex_valid, b1.ex_f, b1.num_vec, b1.start} = {ex_we, ex_addr, ex_valid, ex_f, num_vec, start};
  assign {b0.ex_we, b0.ex_addr, b0.ex_valid, b0.ex_f, b0.num_vec, b0.start} = {ex_we, ex_addr, ex_valid, ex_f, num_vec, start};
  assign {b1.mac_f, b1.mac_valid_out} = {ref_f, ref_v};
  assign {b0.mac_f, b0.mac_valid_out} = {ref_f, ref_v};
  mac_vec_driver #(.W(W), .DEPTH(DEPTH), .CHECK_VALID(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mac_vec_driver #(.W(W), .DEPTH(DEPTH), .CHECK_VALID(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  always #5 clk = ~clk;
  // Reference accumulator: clear dominates, f += a*b on valid_in, valid_out follows valid_in by one cycle.
  always @(posedge clk) begin
    if (b1.mac_clr) begin
      ref_f <= '0;
      ref_v <= 1'b0;
    end else begin
      ref_v <= b1.mac_valid_in;
      if (b1.mac_valid_in) ref_f <= ref_f + $signed(b1.mac_a) * $signed(b1.mac_b);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic load(input int i, input int a, input int b, input bit v, input bit c, input bit ev, input int ef);
    st_we = 1; ex_we = 1; st_addr = AW'(i); ex_addr = AW'(i);
    st_a = W'(a); st_b = W'(b); st_valid = v; st_clr = c; ex_valid = ev; ex_f = (2*W)'(ef);
    @(negedge clk);
    st_we = 0; ex_we = 0;
  endtask
  task automatic load_basic();
    load(0, 3, 4, 1, 0, 0, 0);
    load(1, 5, -2, 1, 0, 1, 12);
    load(2, 1, 1, 1, 0, 1, 2);
  endtask
  // dc = cycle after the start edge in which done is seen (0 on timeout), bc = busy cycles.
  task automatic run(input int n, output int dc, output int bc);
    num_vec = (AW+1)'(n); start = 1;
    @(negedge clk);
    start = 0; dc = 0; bc = 0;
    for (int k = 1; k <= n + 10; k++) begin
      bc += int'(b1.busy);
      if (b1.done) begin dc = k; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    tests++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b want 00", b1.busy, b1.done); end
    tests++; if (b1.pass !== 1'b0) begin fails++; $display("FAIL reset_pass: got %b want 0", b1.pass); end
    tests++; if (b1.err_count !== 16'd0 || b1.first_err !== '0) begin fails++; $display("FAIL reset_err: got %0d/%0d want 0/0", b1.err_count, b1.first_err); end
    got_p = {b1.mac_a, b1.mac_b, b1.mac_valid_in, b1.mac_clr}; exp_p = 22'd1;
    tests++; if (got_p !== exp_p) begin fails++; $display("FAIL reset_mac_idle: got %h want %h", got_p, exp_p); end
    reset = 1;
    @(negedge clk);
  endtask
  task automatic test_timing();
    load_basic();
    num_vec = 3; start = 1;
    @(negedge clk);
    start = 0;
    tests++; if (b1.busy !== 1'b1 || b1.mac_clr !== 1'b1) begin fails++; $display("FAIL prime: got busy=%b clr=%b want 1 1", b1.busy, b1.mac_clr); end
    @(negedge clk);
    got_p = {b1.mac_a, b1.mac_b, b1.mac_valid_in, b1.mac_clr}; exp_p = {10'd3, 10'd4, 1'b1, 1'b0};
    tests++; if (got_p !== exp_p) begin fails++; $display("FAIL vec0_ports: got %h want %h", got_p, exp_p); end
    @(negedge clk);
    got_p = {b1.mac_a, b1.mac_b, b1.mac_valid_in, b1.mac_clr}; exp_p = {10'd5, 10'h3FE, 1'b1, 1'b0};
    tests++; if (got_p !== exp_p) begin fails++; $display("FAIL vec1_ports: got %h want %h", got_p, exp_p); end
    @(negedge clk);
    tests++; if (b1.mac_a !== 10'd1 || b1.busy !== 1'b1 || b1.done !== 1'b0) begin fails++; $display("FAIL vec2_ports: got a=%0d busy=%b done=%b want 1 1 0", b1.mac_a, b1.busy, b1.done); end
    @(negedge clk);
    tests++; if (b1.done !== 1'b1 || b1.busy !== 1'b0 || b1.mac_clr !== 1'b1) begin fails++; $display("FAIL done_cycle: got done=%b busy=%b clr=%b want 1 0 1", b1.done, b1.busy, b1.mac_clr); end
    @(negedge clk);
    tests++; if (b1.done !== 1'b0 || b1.pass !== 1'b1) begin fails++; $display("FAIL after_done: got done=%b pass=%b want 0 1", b1.done, b1.pass); end
  endtask
  task automatic test_basic();
    int dc, bc;
    run(3, dc, bc);
    tests++; if (dc !== 5 || bc !== 4) begin fails++; $display("FAIL basic_timing: got done@%0d busy=%0d want 5 4", dc, bc); end
    tests++; if (b1.err_count !== 16'd0 || b1.pass !== 1'b1) begin fails++; $display("FAIL basic_status: got err=%0d pass=%b want 0 1", b1.err_count, b1.pass); end
  endtask
  task automatic test_corrupt();
    int dc, bc;
    load(1, 5, -2, 1, 0, 1, 13);
    run(3, dc, bc);
    tests++; if (b1.err_count !== 16'd1 || b1.first_err !== 10'd1 || b1.pass !== 1'b0) begin fails++; $display("FAIL corrupt: got err=%0d first=%0d pass=%b want 1 1 0", b1.err_count, b1.first_err, b1.pass); end
    load(1, 5, -2, 1, 0, 1, 12);
  endtask
  task automatic test_check_valid();
    int dc, bc;
    load(0, 3, 4, 1, 0, 1, 0);
    run(3, dc, bc);
    tests++; if (b0.err_count !== 16'd0 || b0.pass !== 1'b1) begin fails++; $display("FAIL cv0: got err=%0d pass=%b want 0 1", b0.err_count, b0.pass); end
    tests++; if (b1.err_count !== 16'd1 || b1.first_err !== 10'd0 || b1.pass !== 1'b0) begin fails++; $display("FAIL cv1: got err=%0d first=%0d pass=%b want 1 0 0", b1.err_count, b1.first_err, b1.pass); end
    load(0, 3, 4, 1, 0, 0, 0);
  endtask
  task automatic test_zero();
    int dc, bc;
    run(0, dc, bc);
    tests++; if (dc !== 1 || bc !== 0 || b1.pass !== 1'b1) begin fails++; $display("FAIL zero: got done@%0d busy=%0d pass=%b want 1 0 1", dc, bc, b1.pass); end
  endtask
  task automatic test_start_ignored();
    num_vec = 3; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    num_vec = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    tests++; if (b1.done !== 1'b1) begin fails++; $display("FAIL start_in_run: got done=%b want 1", b1.done); end
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    tests++; if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin fails++; $display("FAIL start_in_done: got done=%b busy=%b want 0 0", b1.done, b1.busy); end
    tests++; if (b1.err_count !== 16'd0 || b1.pass !== 1'b1) begin fails++; $display("FAIL start_ignored_status: got err=%0d pass=%b want 0 1", b1.err_count, b1.pass); end
  endtask
  task automatic test_reset_mid();
    int dc, bc, d;
    for (int i = 0; i < 10; i++) load(i, i + 1, 2, 1, 0, i != 0, i * (i + 1));
    load(0, 1, 2, 1, 0, 1, 0);
    num_vec = 10; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    tests++; if (b1.err_count !== 16'd1 || b1.mac_a !== 10'd3) begin fails++; $display("FAIL mid_before_reset: got err=%0d a=%0d want 1 3", b1.err_count, b1.mac_a); end
    reset = 0;
    @(negedge clk);
    reset = 1;
    tests++; if (b1.mac_clr !== 1'b1 || b1.busy !== 1'b0 || b1.err_count !== 16'd0) begin fails++; $display("FAIL mid_reset: got clr=%b busy=%b err=%0d want 1 0 0", b1.mac_clr, b1.busy, b1.err_count); end
    d = 0;
    for (int k = 0; k < 15; k++) begin d += int'(b1.done); @(negedge clk); end
    tests++; if (d !== 0) begin fails++; $display("FAIL mid_no_done: got %0d done cycles want 0", d); end
    load(0, 1, 2, 1, 0, 0, 0);
    run(10, dc, bc);
    tests++; if (dc !== 12 || b1.err_count !== 16'd0 || b1.pass !== 1'b1) begin fails++; $display("FAIL restart: got done@%0d err=%0d pass=%b want 12 0 1", dc, b1.err_count, b1.pass); end
  endtask
  task automatic test_all_mismatch();
    int dc, bc;
    for (int i = 0; i < DEPTH; i++) load(i, 0, 0, 0, 1, 1, 0);
    for (int r = 0; r < 2; r++) begin
      run(DEPTH, dc, bc);
      tests++; if (dc !== DEPTH + 2 || bc !== DEPTH + 1) begin fails++; $display("FAIL full_timing%0d: got done@%0d busy=%0d want %0d %0d", r, dc, bc, DEPTH + 2, DEPTH + 1); end
      tests++; if (b1.err_count !== 16'd1024 || b1.first_err !== 10'd0 || b1.pass !== 1'b0) begin fails++; $display("FAIL full_err%0d: got err=%0d first=%0d pass=%b want 1024 0 0", r, b1.err_count, b1.first_err, b1.pass); end
    end
    run(100, dc, bc);
    tests++; if (b1.err_count !== 16'd100) begin fails++; $display("FAIL partial_err: got %0d want 100", b1.err_count); end
    run(2000, dc, bc);
    tests++; if (dc !== DEPTH + 2 || b1.err_count !== 16'd1024) begin fails++; $display("FAIL clamp: got done@%0d err=%0d want %0d 1024", dc, b1.err_count, DEPTH + 2); end
    load(0, 0, 0, 0, 1, 0, 0);
    run(5, dc, bc);
    tests++; if (b1.err_count !== 16'd4 || b1.first_err !== 10'd1) begin fails++; $display("FAIL first_err_idx: got err=%0d first=%0d want 4 1", b1.err_count, b1.first_err); end
  endtask
  task automatic test_saturate();
    int dc;
    num_vec = DEPTH; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    force dut1.err_count_q = 16'hFFF0;
    repeat (2) @(negedge clk);
    release dut1.err_count_q;
    dc = 0;
    for (int k = 0; k < DEPTH + 10; k++) begin
      if (b1.done) begin dc = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    tests++; if (dc !== 1) begin fails++; $display("FAIL sat_done: got %0d want 1", dc); end
    tests++; if (b1.err_count !== 16'hFFFF || b1.pass !== 1'b0) begin fails++; $display("FAIL saturate: got err=%h pass=%b want ffff 0", b1.err_count, b1.pass); end
  endtask
  initial begin
    test_reset();
    test_timing();
    test_basic();
    test_corrupt();
    test_check_valid();
    test_zero();
    test_start_ignored();
    test_reset_mid();
    test_all_mismatch();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
